// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the banked register file and its scoreboard.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package regfile_pkg;

   localparam int BANK_INT = 0;
   localparam int BANK_FP  = 1;

   localparam logic W_MODE_DATA = 1'b0;
   localparam logic W_MODE_MOVE = 1'b1;

   // Bank select width: at least one bit even when only two banks exist.
   function automatic int bank_w(input int nbanks);
      return (nbanks > 2) ? $clog2(nbanks) : 1;
   endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write busy bits with set-over-clear priority and two lookups.
// Latency: set/clear take effect after the rising edge; lookups are combinational.
// Backpressure: none; every set/clear presented is absorbed the same cycle.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int ADDR_W   = 5,
   parameter int NBANKS   = 2,
   parameter int ZERO_REG = 1,
   localparam int BANK_W  = bank_w(NBANKS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              set_vld_i,
   input  logic [BANK_W-1:0] set_bank_i,
   input  logic [ADDR_W-1:0] set_addr_i,
   input  logic              clr_vld_i,
   input  logic [BANK_W-1:0] clr_bank_i,
   input  logic [ADDR_W-1:0] clr_addr_i,
   input  logic [BANK_W-1:0] a_bank_i,
   input  logic [ADDR_W-1:0] a_addr_i,
   output logic              a_busy_o,
   input  logic [BANK_W-1:0] b_bank_i,
   input  logic [ADDR_W-1:0] b_addr_i,
   output logic              b_busy_o
);

   // Slots are indexed by {bank, addr}; slots of nonexistent banks are never set.
   localparam int NSLOTS = 2 ** (BANK_W + ADDR_W);
   localparam logic [BANK_W:0] NB = (BANK_W + 1)'(NBANKS);

   logic [NSLOTS-1:0] busy_q;
   logic [NSLOTS-1:0] busy_d;
   logic              set_ok;

   // Next busy state: clear first, then set so a new producer wins over retirement.
   always_comb begin
      set_ok = set_vld_i && ({1'b0, set_bank_i} < NB)
               && !((ZERO_REG != 0) && (set_bank_i == '0) && (set_addr_i == '0));
      busy_d = busy_q;
      if (clr_vld_i) busy_d[{clr_bank_i, clr_addr_i}] = 1'b0;
      if (set_ok)    busy_d[{set_bank_i, set_addr_i}] = 1'b1;
   end

   // Busy-bit storage, cleared asynchronously.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) busy_q <= '0;
      else        busy_q <= busy_d;
   end

   assign a_busy_o = busy_q[{a_bank_i, a_addr_i}];
   assign b_busy_o = busy_q[{b_bank_i, b_addr_i}];

endmodule

// File: rtl/banked_regfile.sv
// Multi-bank register file: two combinational read ports, one write port (data or move), RAW scoreboard.
// Latency: reads 0 cycles (same-cycle write forwarded when BYPASS=1); writes land on the rising edge.
// Backpressure: none; decode stalls itself on ra_busy/rb_busy.
module banked_regfile
   import regfile_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NBANKS   = 2,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1,
   localparam int BANK_W  = bank_w(NBANKS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [BANK_W-1:0] ra_bank,
   input  logic [ADDR_W-1:0] ra_addr,
   output logic [DATA_W-1:0] ra_data,
   output logic              ra_busy,
   input  logic [BANK_W-1:0] rb_bank,
   input  logic [ADDR_W-1:0] rb_addr,
   output logic [DATA_W-1:0] rb_data,
   output logic              rb_busy,
   input  logic              we,
   input  logic              w_mode,
   input  logic [BANK_W-1:0] w_bank,
   input  logic [ADDR_W-1:0] w_addr,
   input  logic [DATA_W-1:0] w_data,
   input  logic              sb_set,
   input  logic [BANK_W-1:0] sb_bank,
   input  logic [ADDR_W-1:0] sb_addr
);

   localparam int NSLOTS = 2 ** (BANK_W + ADDR_W);
   localparam logic [BANK_W:0] NB = (BANK_W + 1)'(NBANKS);

   logic [DATA_W-1:0] mem_q [NSLOTS];
   logic [DATA_W-1:0] ra_stored, rb_stored, eff;
   logic              ra_ok, rb_ok, w_ok, ra_hit, rb_hit;
   logic              ra_sb_same, rb_sb_same, ra_busy_raw, rb_busy_raw;

   // Stored reads, move source, write qualification and same-cycle forwarding.
   always_comb begin
      ra_ok     = ({1'b0, ra_bank} < NB);
      rb_ok     = ({1'b0, rb_bank} < NB);
      ra_stored = ra_ok ? mem_q[{ra_bank, ra_addr}] : '0;
      rb_stored = rb_ok ? mem_q[{rb_bank, rb_addr}] : '0;
      // Move source is the un-forwarded stored value, so there is no loop through ra_data.
      eff       = (w_mode == W_MODE_MOVE) ? ra_stored : w_data;
      // Writes to a missing bank or the hardwired zero register are dropped (and never forwarded).
      w_ok      = we && ({1'b0, w_bank} < NB)
                  && !((ZERO_REG != 0) && (w_bank == '0) && (w_addr == '0));
      ra_hit    = (BYPASS != 0) && w_ok && (ra_bank == w_bank) && (ra_addr == w_addr);
      rb_hit    = (BYPASS != 0) && w_ok && (rb_bank == w_bank) && (rb_addr == w_addr);
      ra_sb_same = sb_set && (sb_bank == ra_bank) && (sb_addr == ra_addr);
      rb_sb_same = sb_set && (sb_bank == rb_bank) && (sb_addr == rb_addr);
      ra_data   = ra_hit ? eff : ra_stored;
      rb_data   = rb_hit ? eff : rb_stored;
      // A forwarded register is no longer pending unless a new producer claims it this cycle.
      ra_busy   = ra_ok && (ra_hit ? ra_sb_same : ra_busy_raw);
      rb_busy   = rb_ok && (rb_hit ? rb_sb_same : rb_busy_raw);
   end

   // Register storage: asynchronous clear, one write per rising edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NSLOTS; i++) mem_q[i] <= '0;
      end else if (w_ok) begin
         mem_q[{w_bank, w_addr}] <= eff;
      end
   end

   regfile_scoreboard #(
      .ADDR_W   (ADDR_W),
      .NBANKS   (NBANKS),
      .ZERO_REG (ZERO_REG)
   ) u_sb (
      .clk        (clk),
      .reset      (reset),
      .set_vld_i  (sb_set),
      .set_bank_i (sb_bank),
      .set_addr_i (sb_addr),
      .clr_vld_i  (w_ok),
      .clr_bank_i (w_bank),
      .clr_addr_i (w_addr),
      .a_bank_i   (ra_bank),
      .a_addr_i   (ra_addr),
      .a_busy_o   (ra_busy_raw),
      .b_bank_i   (rb_bank),
      .b_addr_i   (rb_addr),
      .b_busy_o   (rb_busy_raw)
   );

endmodule

// File: tb/tb_banked_regfile.sv
// Bench for banked_regfile: default build (2 banks, bypass) plus a 3-bank 64-bit no-bypass build.
// Latency: inputs driven on the falling edge, outputs sampled 1ns later, state moves on the rising edge.
// Backpressure: n/a.
module tb_banked_regfile;

   logic clk, reset;

   // Default instance: DATA_W=32, NBANKS=2, BYPASS=1, ZERO_REG=1.
   logic [0:0]  ra_bank, rb_bank, w_bank, sb_bank;
   logic [4:0]  ra_addr, rb_addr, w_addr, sb_addr;
   logic [31:0] ra_data, rb_data, w_data;
   logic        ra_busy, rb_busy, we, w_mode, sb_set;

   // Alternate instance: DATA_W=64, NBANKS=3, BYPASS=0.
   logic [1:0]  a_ra_bank, a_rb_bank, a_w_bank, a_sb_bank;
   logic [4:0]  a_ra_addr, a_rb_addr, a_w_addr, a_sb_addr;
   logic [63:0] a_ra_data, a_rb_data, a_w_data;
   logic        a_ra_busy, a_rb_busy, a_we, a_w_mode, a_sb_set;

   int n_pass  = 0;
   int n_total = 0;

   banked_regfile #(.DATA_W(32), .ADDR_W(5), .NBANKS(2), .ZERO_REG(1), .BYPASS(1)) u_dut (
      .clk(clk), .reset(reset),
      .ra_bank(ra_bank), .ra_addr(ra_addr), .ra_data(ra_data), .ra_busy(ra_busy),
      .rb_bank(rb_bank), .rb_addr(rb_addr), .rb_data(rb_data), .rb_busy(rb_busy),
      .we(we), .w_mode(w_mode), .w_bank(w_bank), .w_addr(w_addr), .w_data(w_data),
      .sb_set(sb_set), .sb_bank(sb_bank), .sb_addr(sb_addr)
   );

   banked_regfile #(.DATA_W(64), .ADDR_W(5), .NBANKS(3), .ZERO_REG(1), .BYPASS(0)) u_alt (
      .clk(clk), .reset(reset),
      .ra_bank(a_ra_bank), .ra_addr(a_ra_addr), .ra_data(a_ra_data), .ra_busy(a_ra_busy),
      .rb_bank(a_rb_bank), .rb_addr(a_rb_addr), .rb_data(a_rb_data), .rb_busy(a_rb_busy),
      .we(a_we), .w_mode(a_w_mode), .w_bank(a_w_bank), .w_addr(a_w_addr), .w_data(a_w_data),
      .sb_set(a_sb_set), .sb_bank(a_sb_bank), .sb_addr(a_sb_addr)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic        we;
      logic        w_mode;
      logic        w_bank;
      logic [4:0]  w_addr;
      logic [31:0] w_data;
      logic        ra_bank;
      logic [4:0]  ra_addr;
      logic        rb_bank;
      logic [4:0]  rb_addr;
      logic        sb_set;
      logic        sb_bank;
      logic [4:0]  sb_addr;
      logic [31:0] exp_ra;
      logic [31:0] exp_rb;
      logic        exp_ra_busy;
      logic        exp_rb_busy;
   } vec_t;

   localparam int NVEC = 21;
   vec_t vecs [NVEC];

   function automatic vec_t mk(
      input logic we_v, input logic md, input logic wb, input logic [4:0] wa, input logic [31:0] wd,
      input logic rab, input logic [4:0] raa, input logic rbb, input logic [4:0] rba,
      input logic sb, input logic sbb, input logic [4:0] sba,
      input logic [31:0] era, input logic [31:0] erb, input logic eab, input logic ebb);
      vec_t v;
      v.we = we_v; v.w_mode = md; v.w_bank = wb; v.w_addr = wa; v.w_data = wd;
      v.ra_bank = rab; v.ra_addr = raa; v.rb_bank = rbb; v.rb_addr = rba;
      v.sb_set = sb; v.sb_bank = sbb; v.sb_addr = sba;
      v.exp_ra = era; v.exp_rb = erb; v.exp_ra_busy = eab; v.exp_rb_busy = ebb;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   logic [63:0] v64 [4];
   logic [63:0] exp64;

   initial begin
      // Columns: we md wb wa wdata | ra | rb | sb_set sbb sba | exp_ra exp_rb busyA busyB
      vecs[0]  = mk(0,0,0,5'd0,32'h0,         0,5'd7, 1,5'd5, 0,0,5'd0, 32'h0,        32'h0,        0,0);
      vecs[1]  = mk(1,0,0,5'd7,32'hDEADBEEF,  0,5'd7, 0,5'd7, 0,0,5'd0, 32'hDEADBEEF, 32'hDEADBEEF, 0,0);
      vecs[2]  = mk(0,0,0,5'd0,32'h0,         0,5'd7, 0,5'd3, 0,0,5'd0, 32'hDEADBEEF, 32'h0,        0,0);
      vecs[3]  = mk(1,0,0,5'd3,32'hA5A5A5A5,  0,5'd3, 0,5'd7, 0,0,5'd0, 32'hA5A5A5A5, 32'hDEADBEEF, 0,0);
      vecs[4]  = mk(1,1,1,5'd9,32'h11111111,  0,5'd3, 1,5'd9, 0,0,5'd0, 32'hA5A5A5A5, 32'hA5A5A5A5, 0,0);
      vecs[5]  = mk(0,0,0,5'd0,32'h0,         0,5'd3, 1,5'd9, 0,0,5'd0, 32'hA5A5A5A5, 32'hA5A5A5A5, 0,0);
      vecs[6]  = mk(1,0,0,5'd0,32'hFFFFFFFF,  0,5'd0, 1,5'd0, 1,0,5'd0, 32'h0,        32'h0,        0,0);
      vecs[7]  = mk(1,0,1,5'd0,32'hFFFFFFFF,  0,5'd0, 1,5'd0, 0,0,5'd0, 32'h0,        32'hFFFFFFFF, 0,0);
      vecs[8]  = mk(0,0,0,5'd0,32'h0,         0,5'd0, 1,5'd4, 1,1,5'd4, 32'h0,        32'h0,        0,0);
      vecs[9]  = mk(0,0,0,5'd0,32'h0,         1,5'd0, 1,5'd4, 0,0,5'd0, 32'hFFFFFFFF, 32'h0,        0,1);
      vecs[10] = mk(1,0,1,5'd4,32'h00004444,  1,5'd4, 1,5'd4, 0,0,5'd0, 32'h00004444, 32'h00004444, 0,0);
      vecs[11] = mk(0,0,0,5'd0,32'h0,         1,5'd4, 0,5'd0, 0,0,5'd0, 32'h00004444, 32'h0,        0,0);
      vecs[12] = mk(0,0,0,5'd0,32'h0,         1,5'd4, 1,5'd9, 1,1,5'd4, 32'h00004444, 32'hA5A5A5A5, 0,0);
      vecs[13] = mk(1,0,1,5'd4,32'h00005555,  1,5'd4, 1,5'd4, 1,1,5'd4, 32'h00005555, 32'h00005555, 1,1);
      vecs[14] = mk(0,0,0,5'd0,32'h0,         1,5'd4, 1,5'd9, 0,0,5'd0, 32'h00005555, 32'hA5A5A5A5, 1,0);
      vecs[15] = mk(1,0,1,5'd4,32'h00006666,  1,5'd4, 0,5'd3, 0,0,5'd0, 32'h00006666, 32'hA5A5A5A5, 0,0);
      vecs[16] = mk(0,0,0,5'd0,32'h0,         1,5'd4, 0,5'd3, 0,0,5'd0, 32'h00006666, 32'hA5A5A5A5, 0,0);
      vecs[17] = mk(1,1,0,5'd7,32'h0,         0,5'd7, 0,5'd7, 0,0,5'd0, 32'hDEADBEEF, 32'hDEADBEEF, 0,0);
      vecs[18] = mk(0,0,0,5'd0,32'h0,         0,5'd7, 0,5'd3, 0,0,5'd0, 32'hDEADBEEF, 32'hA5A5A5A5, 0,0);
      vecs[19] = mk(1,0,1,5'd5,32'h00001234,  1,5'd5, 0,5'd2, 1,0,5'd2, 32'h00001234, 32'h0,        0,0);
      vecs[20] = mk(0,0,0,5'd0,32'h0,         1,5'd5, 0,5'd2, 0,0,5'd0, 32'h00001234, 32'h0,        0,1);

      v64[0] = 64'h0123_4567_89AB_CDEF;
      v64[1] = 64'hFEDC_BA98_7654_3210;
      v64[2] = 64'h5555_AAAA_0F0F_F0F0;
      v64[3] = 64'h8000_0000_0000_0001;

      reset = 1'b0;
      we = 0; w_mode = 0; w_bank = 0; w_addr = 0; w_data = 0;
      ra_bank = 0; ra_addr = 0; rb_bank = 0; rb_addr = 0;
      sb_set = 0; sb_bank = 0; sb_addr = 0;
      a_we = 0; a_w_mode = 0; a_w_bank = 0; a_w_addr = 0; a_w_data = 0;
      a_ra_bank = 0; a_ra_addr = 0; a_rb_bank = 0; a_rb_addr = 0;
      a_sb_set = 0; a_sb_bank = 0; a_sb_addr = 0;
      repeat (2) @(negedge clk);
      reset = 1'b1;

      // Table: inputs at the falling edge, combinational outputs checked before the next rising edge.
      for (int i = 0; i < NVEC; i++) begin
         @(negedge clk);
         we = vecs[i].we; w_mode = vecs[i].w_mode; w_bank = vecs[i].w_bank;
         w_addr = vecs[i].w_addr; w_data = vecs[i].w_data;
         ra_bank = vecs[i].ra_bank; ra_addr = vecs[i].ra_addr;
         rb_bank = vecs[i].rb_bank; rb_addr = vecs[i].rb_addr;
         sb_set = vecs[i].sb_set; sb_bank = vecs[i].sb_bank; sb_addr = vecs[i].sb_addr;
         #1;
         check($sformatf("vec%0d ra_data", i), 64'(ra_data), 64'(vecs[i].exp_ra));
         check($sformatf("vec%0d rb_data", i), 64'(rb_data), 64'(vecs[i].exp_rb));
         check($sformatf("vec%0d ra_busy", i), 64'(ra_busy), 64'(vecs[i].exp_ra_busy));
         check($sformatf("vec%0d rb_busy", i), 64'(rb_busy), 64'(vecs[i].exp_rb_busy));
      end

      // Mid-cycle asynchronous reset with a write to bank1 r6 in flight.
      @(negedge clk);
      we = 1; w_mode = 0; w_bank = 1; w_addr = 5'd6; w_data = 32'h00009999;
      ra_bank = 1; ra_addr = 5'd5; rb_bank = 0; rb_addr = 5'd2; sb_set = 0;
      #1;
      check("pre-reset b1r5", 64'(ra_data), 64'h1234);
      check("pre-reset b0r2 busy", 64'(rb_busy), 64'h1);
      #1 reset = 1'b0;
      #1;
      check("reset b1r5 data", 64'(ra_data), 64'h0);
      check("reset b0r2 busy", 64'(rb_busy), 64'h0);
      @(posedge clk);
      @(negedge clk);
      we = 0; rb_bank = 1; rb_addr = 5'd6;
      #1;
      check("reset dropped write b1r6", 64'(rb_data), 64'h0);
      reset = 1'b1;
      @(negedge clk);
      #1;
      check("post-reset b1r6", 64'(rb_data), 64'h0);
      check("post-reset b1r5", 64'(ra_data), 64'h0);

      // No-bypass build: old value before the edge, new value after.
      @(negedge clk);
      a_we = 1; a_w_bank = 2'd0; a_w_addr = 5'd7; a_w_data = 64'hDEADBEEF;
      a_ra_bank = 2'd0; a_ra_addr = 5'd7;
      #1;
      check("nobyp before edge", a_ra_data, 64'h0);
      @(negedge clk);
      a_we = 0;
      #1;
      check("nobyp after edge", a_ra_data, 64'hDEADBEEF);

      // Three banks: r31 in every bank index incl. the missing bank 3; sb_set r30 alongside.
      for (int b = 0; b < 4; b++) begin
         @(negedge clk);
         a_we = 1; a_w_mode = 0; a_w_bank = 2'(b); a_w_addr = 5'd31; a_w_data = v64[b];
         a_sb_set = 1; a_sb_bank = 2'(b); a_sb_addr = 5'd30;
      end
      @(negedge clk);
      a_we = 0; a_sb_set = 0;
      for (int b = 0; b < 4; b++) begin
         @(negedge clk);
         a_ra_bank = 2'(b); a_ra_addr = 5'd31;
         a_rb_bank = 2'(b); a_rb_addr = 5'd30;
         #1;
         exp64 = (b < 3) ? v64[b] : 64'h0;
         check($sformatf("bank%0d r31 data", b), a_ra_data, exp64);
         check($sformatf("bank%0d r30 busy", b), 64'(a_rb_busy), (b < 3) ? 64'h1 : 64'h0);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/banked_regfile.md
Name: banked_regfile

Overview:
- Parametrised multi-bank register file for the pipelined datapath, replacing the fixed int/fp two-bank file.
- Provides two combinational read ports and one synchronous write port, with the write port able to take either bus data or a cross-bank move.
- Forwards a same-cycle write to the read ports.
- Keeps a per-register scoreboard of pending writes, so decode can stall on RAW hazards from multi-cycle producers.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register index width; each bank has 2**ADDR_W entries.
- NBANKS, 2, number of banks (bank 0 = integer, bank 1 = fp by convention); minimum 2.
- ZERO_REG, 1, when 1, bank 0 entry 0 reads as 0 and ignores writes.
- BYPASS, 1, when 1, a same-cycle write is forwarded to the read ports.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- ra_bank  in  BANK_W  port A bank select; BANK_W = max(1, clog2(NBANKS)).
- ra_addr  in  ADDR_W  port A register index.
- ra_data  out  DATA_W  port A read data.
- ra_busy  out  1  port A register has a pending write.
- rb_bank  in  BANK_W  port B bank select.
- rb_addr  in  ADDR_W  port B register index.
- rb_data  out  DATA_W  port B read data.
- rb_busy  out  1  port B register has a pending write.
- we  in  1  write enable.
- w_mode  in  1  0 = write w_data; 1 = move, i.e. write the stored value of port A's register.
- w_bank  in  BANK_W  write bank.
- w_addr  in  ADDR_W  write index.
- w_data  in  DATA_W  write data.
- sb_set  in  1  mark (sb_bank, sb_addr) pending.
- sb_bank  in  BANK_W  scoreboard set bank.
- sb_addr  in  ADDR_W  scoreboard set index.

Behaviour:
- Reset (reset=0, asynchronous):
  - All registers in all banks clear to 0; all busy bits clear to 0.
  - Outputs then read 0 / not-busy, subject to the bypass and forwarding rules below.
  - Reset mid-cycle discards any in-flight write or sb_set.
  - Deassertion is sampled on clk.
- Reads:
  - Combinational, zero latency.
  - ra_data = mem[ra_bank][ra_addr], and likewise for rb_data.
  - A bank index >= NBANKS reads 0 and busy=0.
- Effective write value (eff):
  - w_mode=0: eff = w_data.
  - w_mode=1: eff = stored mem[ra_bank][ra_addr], un-bypassed, so there is no combinational loop. This generalises int<->fp moves to any bank pair.
- Write:
  - On the clk rising edge with we=1, mem[w_bank][w_addr] <= eff.
  - Dropped if w_bank >= NBANKS, or if ZERO_REG and w_bank=0 and w_addr=0.
- Bypass (BYPASS=1):
  - If we=1 and (w_bank, w_addr) equals a read port's (bank, addr), that port returns eff in the same cycle.
  - Not applied to zero-reg reads, which stay 0.
  - With BYPASS=0, the new value is visible the cycle after the edge.
- Scoreboard:
  - One busy bit per register.
  - Rising edge with sb_set=1 sets busy[sb_bank][sb_addr].
  - Rising edge with we=1 clears busy[w_bank][w_addr].
  - Same register set and cleared in one cycle: set wins (new producer issued).
  - sb_set to the zero register, or to a bank >= NBANKS, is ignored.
  - ra_busy/rb_busy read the bit combinationally.
  - When BYPASS=1, a port matching a same-cycle write reports busy=0, unless sb_set targets that same register this cycle.
- Simultaneous events:
  - A read of the register being written returns the bypassed eff (BYPASS=1), otherwise the old value.
  - Read ports A and B may address the same register; both return identical data.
  - A move whose destination equals its own source rewrites the same value, with no change.
- Widths: no arithmetic; data passes unmodified at DATA_W.

Decomposition:
- Shared package (regfile_pkg):
  - BANK_INT=0 and BANK_FP=1 constants.
  - W_MODE_DATA=0 and W_MODE_MOVE=1 constants.
  - BANK_W derivation function.
- Sub-module regfile_scoreboard: busy-bit array with set/clear priority and two combinational lookup ports, instantiated once.
- Storage, bypass and move mux stay in the top module.

Test Plan:
- Reset: write 0x1234 to bank1 r5, then assert reset=0 mid-cycle -> ra_data for bank1 r5 = 0 immediately; all busy = 0.
- Data write/bypass: we=1, w_mode=0, bank0 r7 <= 0xDEADBEEF, ra=bank0 r7 in the same cycle:
  - BYPASS=1 -> ra_data = 0xDEADBEEF before the edge.
  - BYPASS=0 -> old value before the edge, 0xDEADBEEF after.
- Cross-bank move: bank0 r3 = 0xA5A5A5A5; we=1, w_mode=1, ra=bank0 r3, w=bank1 r9 -> next cycle rb=bank1 r9 reads 0xA5A5A5A5; bank0 r3 unchanged.
- Zero register (ZERO_REG=1): write 0xFFFFFFFF to bank0 r0; sb_set on bank0 r0 -> reads 0, busy 0. Bank1 r0 accepts the write.
- Scoreboard:
  - sb_set bank1 r4 -> rb_busy=1 next cycle.
  - Later, we bank1 r4 -> busy clears after the edge.
  - sb_set and we on bank1 r4 in the same cycle -> busy stays 1.
- Parametrisation: NBANKS=4, DATA_W=64 -> write distinct 64-bit values to r31 in each bank and read all four back correctly; bank index 4+ is not applicable (BANK_W=2). With NBANKS=3, bank 3 reads 0 and writes are dropped.
